// File: rtl/sq_pkg.sv
// sq_pkg: shared definitions for the sq_driver stimulus/check block.
//   state_t      - driver FSM state encoding (IDLE/SEND/DONE)
//   SYM_W        - bits per (a,b) symbol
//   DEFAULT_SYMS - default maximum symbols per burst
//   A_BIT/B_BIT  - position of a and b inside one symbol
//   eff_len()    - maps a requested burst length to the one actually sent
package sq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int SYM_W        = 2;
   localparam int DEFAULT_SYMS = 8;
   localparam int A_BIT        = 1;
   localparam int B_BIT        = 0;

   // A length of zero, or one larger than the burst capacity, means "full burst".
   function automatic logic [3:0] eff_len(input logic [3:0] len, input logic [3:0] max_len);
      if ((len == 4'd0) || (len > max_len)) begin
         return max_len;
      end
      return len;
   endfunction

endpackage

// File: rtl/sq_model.sv
// sq_model: cycle-accurate reference of the two-flop sq_circuit machine.
// Ports:
//   clk, rst      - clock and asynchronous active-high reset (state -> 00)
//   a, b          - the same registered inputs the real machine receives
//   advance       - when high, state follows the machine's next-state logic
//   exp_y, exp_z  - outputs the real machine should present this cycle
module sq_model
   import sq_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic a,
   input  logic b,
   input  logic advance,
   output logic exp_y,
   output logic exp_z
);

   logic q1;
   logic q2;
   logic d1;
   logic d2;

   always_comb begin
      d1    = a | (b & ~q2);
      d2    = ~d1 & q1;
      exp_y = q1;
      exp_z = (b & ~q2) | ~q1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q1 <= 1'b0;
         q2 <= 1'b0;
      end else if (advance) begin
         q1 <= d1;
         q2 <= d2;
      end
   end

endmodule

// File: rtl/sq_driver.sv
// sq_driver: accepts a packed burst of (a,b) symbols and drives it onto the
// sq_circuit machine one symbol per clock, optionally checking y/z against an
// embedded model of the machine.
//
// Build option: define SQ_DRIVER_CHECK_EN to include the model and comparator.
// Without it err/err_cnt stay 0 and y/z are ignored; sequencing is identical.
//
// Handshake: a burst transfers on a rising edge where in_valid and in_ready are
// both high. in_ready is high only in IDLE, so in_valid is ignored elsewhere;
// the requester may hold in_valid and in_data/in_len steady until accepted.
//
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   in_valid    - burst request
//   in_ready    - driver idle and able to accept a burst
//   in_data     - symbols, symbol i at [2i+1:2i] (a at 2i+1, b at 2i)
//   in_len      - symbol count, 0 or > SYMS means SYMS
//   a, b        - registered drive to the machine
//   y, z        - machine outputs
//   busy        - burst symbols being driven
//   done        - one-cycle pulse after the last symbol
//   err         - sticky mismatch flag for the current burst
//   err_cnt     - saturating mismatch count for the current burst
//   state_dbg   - current FSM state
module sq_driver
   import sq_pkg::*;
#(
   parameter int SYMS  = DEFAULT_SYMS,
   parameter int CNT_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [SYM_W*SYMS-1:0] in_data,
   input  logic [3:0]            in_len,
   output logic                  a,
   output logic                  b,
   input  logic                  y,
   input  logic                  z,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [CNT_W-1:0]      err_cnt,
   output state_t                state_dbg
);

   localparam int         DW     = SYM_W * SYMS;
   localparam logic [3:0] SYMS_L = 4'(SYMS);

   state_t          state;
   state_t          state_n;
   logic [DW-1:0]   pend;      // symbols not yet placed on a/b, next one in the low bits
   logic [3:0]      left;      // symbols still to drive after the current one
   logic            last;
   logic            mismatch;

   assign last      = (left == 4'd0);
   assign state_dbg = state;

`ifdef SQ_DRIVER_CHECK_EN
   logic exp_y;
   logic exp_z;

   // The model runs every cycle, including the idle 00 drive between bursts,
   // so it stays in lockstep with the machine which shares clk/rst.
   sq_model u_model (
      .clk     (clk),
      .rst     (rst),
      .a       (a),
      .b       (b),
      .advance (1'b1),
      .exp_y   (exp_y),
      .exp_z   (exp_z)
   );

   // One mismatch per symbol even if both outputs are wrong.
   assign mismatch = (state == SEND) & ((y ^ exp_y) | (z ^ exp_z));
`else
   logic unused_yz;
   assign unused_yz = y ^ z;
   assign mismatch  = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Next state and state-decoded outputs
   always_comb begin
      state_n  = state;
      in_ready = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_n = SEND;
            end
         end
         SEND: begin
            busy = 1'b1;
            if (last) begin
               state_n = DONE;
            end
         end
         DONE: begin
            done    = 1'b1;
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // Symbol drive and mismatch accounting
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a       <= 1'b0;
         b       <= 1'b0;
         pend    <= '0;
         left    <= 4'd0;
         err     <= 1'b0;
         err_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               a <= 1'b0;
               b <= 1'b0;
               if (in_valid) begin
                  // Symbol 0 goes straight onto a/b; the rest wait in pend.
                  a       <= in_data[A_BIT];
                  b       <= in_data[B_BIT];
                  pend    <= in_data >> SYM_W;
                  left    <= eff_len(in_len, SYMS_L) - 4'd1;
                  err     <= 1'b0;
                  err_cnt <= '0;
               end
            end
            SEND: begin
               if (mismatch) begin
                  err <= 1'b1;
                  if (err_cnt != {CNT_W{1'b1}}) begin
                     err_cnt <= err_cnt + 1'b1;
                  end
               end
               if (last) begin
                  a <= 1'b0;
                  b <= 1'b0;
               end else begin
                  a    <= pend[A_BIT];
                  b    <= pend[B_BIT];
                  pend <= pend >> SYM_W;
                  left <= left - 4'd1;
               end
            end
            default: begin
               a <= 1'b0;
               b <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sq_driver.sv
// tb_sq_driver: bench for sq_driver with an attached sq_circuit machine whose
// outputs can be corrupted to provoke mismatches. Works in either build of the
// driver; mismatch expectations are zero when the checker is not compiled in.
module tb_sq_driver;
   import sq_pkg::*;

   localparam int SYMS  = 8;
   localparam int CNT_W = 3;   // small counter so saturation is reachable
`ifdef SQ_DRIVER_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic               clk;
   logic               rst;
   logic               in_valid;
   logic               in_ready;
   logic [2*SYMS-1:0]  in_data;
   logic [3:0]         in_len;
   logic               a;
   logic               b;
   logic               y;
   logic               z;
   logic               busy;
   logic               done;
   logic               err;
   logic [CNT_W-1:0]   err_cnt;
   state_t             state_dbg;

   // fault: 0 none, 1 z stuck 0, 2 y inverted, 3 y and z inverted
   logic [1:0]         fault;
   logic               m_q1;
   logic               m_q2;
   logic               m_y;
   logic               m_z;

   int checks;
   int errors;
   logic [1:0] exp_q[$];

   typedef struct {
      logic [15:0] data;
      logic [3:0]  len;
      logic [1:0]  fault;
      int          n;
      int          cnt;
   } vec_t;

   vec_t vecs[7];

   sq_driver #(.SYMS(SYMS), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_len    (in_len),
      .a         (a),
      .b         (b),
      .y         (y),
      .z         (z),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .err_cnt   (err_cnt),
      .state_dbg (state_dbg)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- machine under drive ----------------
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_q1 <= 1'b0;
         m_q2 <= 1'b0;
      end else begin
         m_q1 <= a | (b & ~m_q2);
         m_q2 <= ~(a | (b & ~m_q2)) & m_q1;
      end
   end

   assign m_y = m_q1;
   assign m_z = (b & ~m_q2) | ~m_q1;
   assign y   = (fault == 2'd2 || fault == 2'd3) ? ~m_y : m_y;
   assign z   = (fault == 2'd1) ? 1'b0 : (fault == 2'd3) ? ~m_z : m_z;

   // ---------------- check helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got timeout expected event", name);
   endtask

   // Leaves the bench at a negedge with in_ready high (or reports a timeout).
   task automatic wait_ready(input string name);
      int t;
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) fail_now(name);
   endtask

   // ---------------- driver task with scoreboard ----------------
   task automatic run_burst(input vec_t v, input int idx);
      int          c;
      bit          seen_done;
      logic [1:0]  e;
      logic [15:0] d;
      int          ecnt;
      ecnt = CHK ? v.cnt : 0;
      wait_ready($sformatf("v%0d ready", idx));
      d = v.data;
      for (int i = 0; i < v.n; i++) exp_q.push_back(d[2*i +: 2]);
      in_data  = v.data;
      in_len   = v.len;
      fault    = v.fault;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      seen_done = 1'b0;
      c = 0;
      while (!seen_done && c < 20) begin
         @(negedge clk);
         c++;
         if (busy) begin
            check($sformatf("v%0d ready_low_c%0d", idx, c), {31'd0, in_ready}, 32'd0);
            if (exp_q.size() == 0) begin
               fail_now($sformatf("v%0d sb_underflow", idx));
            end else begin
               e = exp_q.pop_front();
               check($sformatf("v%0d ab_c%0d", idx, c), {30'd0, a, b}, {30'd0, e});
            end
         end
         if (done) begin
            seen_done = 1'b1;
            check($sformatf("v%0d done_cycle", idx), c, v.n + 1);
            check($sformatf("v%0d ab_idle", idx), {30'd0, a, b}, 32'd0);
            check($sformatf("v%0d sb_left", idx), exp_q.size(), 32'd0);
            check($sformatf("v%0d err", idx), {31'd0, err}, {31'd0, (ecnt != 0)});
            check($sformatf("v%0d err_cnt", idx), {29'd0, err_cnt}, ecnt);
         end
      end
      if (!seen_done) fail_now($sformatf("v%0d done", idx));
      exp_q.delete();
      @(negedge clk);
      fault = 2'd0;
      check($sformatf("v%0d ready_back", idx), {31'd0, in_ready}, 32'd1);
      check($sformatf("v%0d done_once", idx), {31'd0, done}, 32'd0);
      check($sformatf("v%0d err_cnt_hold", idx), {29'd0, err_cnt}, ecnt);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      checks   = 0;
      errors   = 0;
      rst      = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      in_len   = 4'd0;
      fault    = 2'd0;

      vecs[0] = '{data: 16'h0046, len: 4'd4, fault: 2'd0, n: 4, cnt: 0};
      vecs[1] = '{data: 16'h0046, len: 4'd4, fault: 2'd1, n: 4, cnt: 3};
      vecs[2] = '{data: 16'hFFFF, len: 4'd0, fault: 2'd0, n: 8, cnt: 0};
      vecs[3] = '{data: 16'h1234, len: 4'd9, fault: 2'd0, n: 8, cnt: 0};
      vecs[4] = '{data: 16'h5A5A, len: 4'd2, fault: 2'd3, n: 2, cnt: 2};
      vecs[5] = '{data: 16'hC3C3, len: 4'd8, fault: 2'd2, n: 8, cnt: 7};
      vecs[6] = '{data: 16'hABCD, len: 4'd1, fault: 2'd0, n: 1, cnt: 0};

      // reset
      #2 rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst in_ready", {31'd0, in_ready}, 32'd1);
      check("rst ab", {30'd0, a, b}, 32'd0);
      check("rst busy", {31'd0, busy}, 32'd0);
      check("rst done", {31'd0, done}, 32'd0);
      check("rst err", {31'd0, err}, 32'd0);
      check("rst err_cnt", {29'd0, err_cnt}, 32'd0);
      check("rst state", {30'd0, state_dbg}, {30'd0, IDLE});
      rst = 1'b0;

      // table-driven bursts
      for (int i = 0; i < 7; i++) run_burst(vecs[i], i);

      // in_valid held through SEND and DONE: one burst per IDLE visit
      wait_ready("held ready");
      in_data  = 16'h0046;
      in_len   = 4'd4;
      in_valid = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         check($sformatf("held busy_c%0d", c), {31'd0, busy},
               {31'd0, ((c >= 1 && c <= 4) || (c >= 7 && c <= 10))});
         check($sformatf("held done_c%0d", c), {31'd0, done},
               {31'd0, (c == 5 || c == 11)});
      end
      in_valid = 1'b0;

      // reset in the middle of a burst
      wait_ready("abort ready");
      in_data  = 16'h0046;
      in_len   = 4'd4;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("abort busy_before", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      #1;
      check("abort ab", {30'd0, a, b}, 32'd0);
      check("abort busy", {31'd0, busy}, 32'd0);
      check("abort in_ready", {31'd0, in_ready}, 32'd1);
      check("abort done", {31'd0, done}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         check($sformatf("abort no_done_c%0d", c), {31'd0, done}, 32'd0);
      end
      run_burst(vecs[1], 7);
      run_burst(vecs[0], 8);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
